ibex_rf_ctx_bank: RTL

//  Multi-context integer register file serving the core's externalised register file port.

---
 rtl/ibex_rf_ctx_bank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ibex_rf_ctx_bank.sv
//------------------------------------------------------------------------------
// ibex_rf_ctx_bank - multi-context GPR bank with previous-context x1 link and a
// background context-clear engine.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ibex_rf_ctx_bank #(
  parameter int                   NumCtx      = 2,
  parameter int                   DataWidth   = 32,
  parameter int                   RV32E       = 0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  localparam int                  CtxW        = (NumCtx > 1) ? $clog2(NumCtx) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CtxW-1:0]      ctx_sel_i,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  output logic [DataWidth-1:0] ra_o,
  input  logic                 clr_req_i,
  input  logic [CtxW-1:0]      clr_ctx_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o
);

  localparam int              NumRegs   = (RV32E != 0) ? 16 : 32;
  localparam int              AddrW     = (RV32E != 0) ? 4 : 5;
  localparam logic [CtxW:0]   c_NUM_CTX = (CtxW + 1)'(NumCtx);
  localparam logic [4:0]      c_LAST    = 5'(NumRegs - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  logic [DataWidth-1:0] r_bank [NumCtx][NumRegs];
  logic [CtxW-1:0]      r_cur_ctx;
  logic [CtxW-1:0]      r_prev_ctx;
  logic [CtxW-1:0]      r_tgt;
  logic [4:0]           r_cnt;
  clr_state_e           r_state;
  clr_state_e           w_state_next;
  logic                 w_start;
  logic                 w_clr_we;
  logic                 w_ctx_ok;
  logic                 w_prev_ok;
  logic                 w_a_ok;
  logic                 w_b_ok;

  // Core write takes priority over the clear engine on the same register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCtx; c++) begin
        for (int r = 0; r < NumRegs; r++) begin
          r_bank[c][r] <= WordZeroVal;
        end
      end
    end else begin
      for (int c = 0; c < NumCtx; c++) begin
        for (int r = 1; r < NumRegs; r++) begin
          if (we_i && (ctx_sel_i == CtxW'(c)) && (waddr_i == 5'(r))) begin
            r_bank[c][r] <= wdata_i;
          end else if (w_clr_we && (r_tgt == CtxW'(c)) && (r_cnt == 5'(r))) begin
            r_bank[c][r] <= WordZeroVal;
          end
        end
      end
    end
  end

  assign w_ctx_ok  = ({1'b0, ctx_sel_i} < c_NUM_CTX);
  assign w_prev_ok = ({1'b0, r_prev_ctx} < c_NUM_CTX);
  assign w_a_ok    = w_ctx_ok && (raddr_a_i != 5'd0) && !((RV32E != 0) && raddr_a_i[4]);
  assign w_b_ok    = w_ctx_ok && (raddr_b_i != 5'd0) && !((RV32E != 0) && raddr_b_i[4]);

  assign rdata_a_o = w_a_ok ? r_bank[ctx_sel_i][raddr_a_i[AddrW-1:0]] : WordZeroVal;
  assign rdata_b_o = w_b_ok ? r_bank[ctx_sel_i][raddr_b_i[AddrW-1:0]] : WordZeroVal;
  assign ra_o      = w_prev_ok ? r_bank[r_prev_ctx][1] : WordZeroVal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur_ctx  <= '0;
      r_prev_ctx <= '0;
    end else begin
      r_cur_ctx <= ctx_sel_i;
      if (ctx_sel_i != r_cur_ctx) begin
        r_prev_ctx <= r_cur_ctx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_clr_we     = 1'b0;
    clr_busy_o   = 1'b0;
    clr_done_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clr_req_i) begin
          w_start      = 1'b1;
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_busy_o = 1'b1;
        w_clr_we   = 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        clr_done_o   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Counter holds at the last index instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tgt <= '0;
      r_cnt <= 5'd0;
    end else if (w_start) begin
      r_tgt <= clr_ctx_i;
      r_cnt <= 5'd1;
    end else if (w_clr_we && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

endmodule

`default_nettype wire
